// File: rtl/aie_trip_ctrl.sv
// aie_trip_ctrl: time-shared envelope-limit trip controller.
// Each accepted frame strobe scans all N_CH channels out of the position RAM,
// checks each sample against the symmetric [-limit, +limit] window and keeps a
// per-channel count of consecutive out-of-limit frames that raises a sticky trip.
// Build option: define AIE_OVERRUN_EN to build the sticky overrun_o flag;
// without it overrun_o is tied low.
module aie_trip_ctrl #(
    parameter int N_CH  = 8,
    parameter int CNT_W = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      enable_i,
    input  logic                      frame_start_i,
    input  logic [31:0]               limit_i,
    input  logic [CNT_W-1:0]          persist_i,
    input  logic                      trip_clr_i,
    output logic                      pos_rd_o,
    output logic [$clog2(N_CH)-1:0]   pos_addr_o,
    input  logic [31:0]               pos_data_i,
    output logic                      busy_o,
    output logic                      scan_done_o,
    output logic                      trip_o,
    output logic [N_CH-1:0]           trip_mask_o,
    output logic [$clog2(N_CH)-1:0]   first_ch_o,
    output logic                      overrun_o
);

    localparam int AW = $clog2(N_CH);
    localparam logic [AW-1:0] ADDR_LAST = AW'(N_CH - 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t             state;
    logic [31:0]        lim_r;
    logic [CNT_W-1:0]   pers_r;
    logic               chk_vld;
    logic [AW-1:0]      chk_ch;
    logic [CNT_W-1:0]   cnt [N_CH];

    logic signed [32:0] p_ext;
    logic signed [32:0] l_ext;
    logic signed [32:0] l_neg;
    logic               in_lim;
    logic [CNT_W-1:0]   cur_cnt;
    logic [CNT_W-1:0]   new_cnt;
    logic [CNT_W-1:0]   pers_eff;
    logic               trip_hit;

    // Scan sequencer: issues one RAM read per cycle, then drains and signals done.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            pos_rd_o    <= 1'b0;
            pos_addr_o  <= '0;
            busy_o      <= 1'b0;
            scan_done_o <= 1'b0;
            lim_r       <= '0;
            pers_r      <= '0;
        end else begin
            scan_done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (frame_start_i && enable_i) begin
                        state      <= READ;
                        pos_rd_o   <= 1'b1;
                        pos_addr_o <= '0;
                        busy_o     <= 1'b1;
                        lim_r      <= limit_i;
                        pers_r     <= persist_i;
                    end
                end
                READ: begin
                    if (pos_addr_o == ADDR_LAST) begin
                        pos_rd_o <= 1'b0;
                        state    <= DRAIN;
                    end else begin
                        pos_addr_o <= pos_addr_o + 1'b1;
                    end
                end
                DRAIN: begin
                    state       <= DONE;
                    scan_done_o <= 1'b1;
                end
                DONE: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Read-return alignment: the RAM answers one cycle after the strobe.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            chk_vld <= 1'b0;
            chk_ch  <= '0;
        end else begin
            chk_vld <= pos_rd_o;
            chk_ch  <= pos_addr_o;
        end
    end

    // Shared comparator: 33-bit signed so negating 0x80000000 cannot wrap.
    always_comb begin
        p_ext    = {pos_data_i[31], pos_data_i};
        l_ext    = {lim_r[31], lim_r};
        l_neg    = -l_ext;
        in_lim   = (p_ext <= l_ext) && (p_ext >= l_neg);
        cur_cnt  = cnt[chk_ch];
        if (in_lim)
            new_cnt = '0;
        else if (cur_cnt == '1)
            new_cnt = cur_cnt;
        else
            new_cnt = cur_cnt + 1'b1;
        pers_eff = (pers_r == '0) ? CNT_W'(1) : pers_r;
        trip_hit = chk_vld && (new_cnt >= pers_eff);
    end

    // Persistence counters and sticky trip state; a trip coinciding with a clear survives it.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < N_CH; i++) cnt[i] <= '0;
            trip_o      <= 1'b0;
            trip_mask_o <= '0;
            first_ch_o  <= '0;
        end else begin
            if (trip_clr_i) begin
                for (int unsigned i = 0; i < N_CH; i++) cnt[i] <= '0;
                trip_o      <= 1'b0;
                trip_mask_o <= '0;
                first_ch_o  <= '0;
            end
            if (chk_vld && (!trip_clr_i || trip_hit))
                cnt[chk_ch] <= new_cnt;
            if (trip_hit) begin
                trip_o              <= 1'b1;
                trip_mask_o[chk_ch] <= 1'b1;
                if (!trip_o || trip_clr_i)
                    first_ch_o <= chk_ch;
            end
        end
    end

`ifdef AIE_OVERRUN_EN
    // Sticky overrun: a frame strobe landed while a scan was still running.
    always_ff @(posedge clk) begin
        if (!reset_n)
            overrun_o <= 1'b0;
        else if (frame_start_i && busy_o)
            overrun_o <= 1'b1;
        else if (trip_clr_i)
            overrun_o <= 1'b0;
    end
`else
    assign overrun_o = 1'b0;
`endif

endmodule

// File: tb/tb_aie_trip_ctrl.sv
// Self-checking bench for aie_trip_ctrl (N_CH=8, CNT_W=4) with a
// frame-level reference model of the persistence/trip rules.
module tb_aie_trip_ctrl;

    localparam int N = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable_i = 1'b1;
    logic        frame_start_i = 1'b0;
    logic [31:0] limit_i = '0;
    logic [3:0]  persist_i = '0;
    logic        trip_clr_i = 1'b0;
    logic        pos_rd_o;
    logic [2:0]  pos_addr_o;
    logic [31:0] pos_data_i = '0;
    logic        busy_o;
    logic        scan_done_o;
    logic        trip_o;
    logic [7:0]  trip_mask_o;
    logic [2:0]  first_ch_o;
    logic        overrun_o;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] mem [N];

    // reference model state
    int       cnt_m [N];
    bit [7:0] mask_m;
    bit       trip_m;
    int       first_m;
    bit       ovr_m;

    aie_trip_ctrl #(.N_CH(8), .CNT_W(4)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable_i     (enable_i),
        .frame_start_i(frame_start_i),
        .limit_i      (limit_i),
        .persist_i    (persist_i),
        .trip_clr_i   (trip_clr_i),
        .pos_rd_o     (pos_rd_o),
        .pos_addr_o   (pos_addr_o),
        .pos_data_i   (pos_data_i),
        .busy_o       (busy_o),
        .scan_done_o  (scan_done_o),
        .trip_o       (trip_o),
        .trip_mask_o  (trip_mask_o),
        .first_ch_o   (first_ch_o),
        .overrun_o    (overrun_o)
    );

    always #5 clk = ~clk;

    // position RAM with one-cycle read latency
    always @(posedge clk) if (pos_rd_o) pos_data_i <= mem[pos_addr_o];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < N; i++) cnt_m[i] = 0;
        mask_m  = '0;
        trip_m  = 1'b0;
        first_m = 0;
        ovr_m   = 1'b0;
    endfunction

    // One whole frame: every channel against [-lim, +lim] in address order.
    function automatic void model_scan(input longint lim, input int pers);
        int need;
        longint p;
        need = (pers == 0) ? 1 : pers;
        for (int ch = 0; ch < N; ch++) begin
            p = longint'($signed(mem[ch]));
            if (p <= lim && p >= -lim) cnt_m[ch] = 0;
            else if (cnt_m[ch] < 15)   cnt_m[ch] = cnt_m[ch] + 1;
            if (cnt_m[ch] >= need) begin
                if (!trip_m) first_m = ch;
                trip_m     = 1'b1;
                mask_m[ch] = 1'b1;
            end
        end
    endfunction

    task automatic check_state(input string tag);
        check({tag, "_trip"},  64'(trip_o),      64'(trip_m));
        check({tag, "_mask"},  64'(trip_mask_o), 64'(mask_m));
        check({tag, "_first"}, 64'(first_ch_o),  64'(first_m));
        check({tag, "_ovr"},   64'(overrun_o),   64'(ovr_m));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_rd"},    64'(pos_rd_o),    64'd0);
        check({tag, "_addr"},  64'(pos_addr_o),  64'd0);
        check({tag, "_busy"},  64'(busy_o),      64'd0);
        check({tag, "_done"},  64'(scan_done_o), 64'd0);
        check({tag, "_trip"},  64'(trip_o),      64'd0);
        check({tag, "_mask"},  64'(trip_mask_o), 64'd0);
        check({tag, "_first"}, 64'(first_ch_o),  64'd0);
        check({tag, "_ovr"},   64'(overrun_o),   64'd0);
    endtask

    // Starts right after a falling edge; returns at cycle N+3 (idle, ready again).
    task automatic do_scan(input logic [31:0] lim, input logic [3:0] pers,
                           input int ovr_cyc, input bit en_drop);
        bit tb_trip;
        bit newtrip;
        int fc;
        tb_trip = trip_m;
        model_scan(longint'($signed(lim)), int'(pers));
        newtrip = trip_m && !tb_trip;
        fc = first_m;
`ifdef AIE_OVERRUN_EN
        if (ovr_cyc > 0) ovr_m = 1'b1;
`endif
        limit_i = lim;
        persist_i = pers;
        frame_start_i = 1'b1;
        for (int c = 1; c <= N + 3; c++) begin
            @(negedge clk);
            if (c <= N + 2) begin
                check("busy", 64'(busy_o), 64'd1);
                check("rd", 64'(pos_rd_o), 64'(c <= N));
                if (c <= N) check("addr", 64'(pos_addr_o), 64'(c - 1));
                check("done", 64'(scan_done_o), 64'(c == N + 2));
                check("trip_time", 64'(trip_o), 64'(tb_trip || (newtrip && c >= fc + 3)));
            end else begin
                check("end_busy", 64'(busy_o), 64'd0);
                check("end_done", 64'(scan_done_o), 64'd0);
                check_state("scan");
            end
            frame_start_i = (c == ovr_cyc);
            if (c == 1) begin
                limit_i   = $urandom;
                persist_i = 4'($urandom);
            end
            if (en_drop && c == 3) enable_i = 1'b0;
        end
        enable_i = 1'b1;
    endtask

    task automatic pulse_clear();
        trip_clr_i = 1'b1;
        @(negedge clk);
        trip_clr_i = 1'b0;
        model_clear();
        @(negedge clk);
        check_state("clr");
    endtask

    task automatic fill_mem(input logic [31:0] v);
        for (int i = 0; i < N; i++) mem[i] = v;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int v;
        int oc;
        model_clear();
        fill_mem('0);

        // reset
        repeat (3) @(negedge clk);
        check_zero("reset");
        reset_n = 1'b1;
        @(negedge clk);
        check_zero("post_reset");

        // in-limit scans
        fill_mem(32'h0010_0000);
        repeat (4) do_scan(32'h0131_2D00, 4'd3, 0, 1'b0);
        check("inlim_mask", 64'(trip_mask_o), 64'h00);

        // persistence trip on ch5, third frame
        fill_mem('0);
        mem[5] = 32'h0131_2D01;
        do_scan(32'h0131_2D00, 4'd3, 0, 1'b0);
        do_scan(32'h0131_2D00, 4'd3, 0, 1'b0);
        check("persist_notrip", 64'(trip_o), 64'd0);
        do_scan(32'h0131_2D00, 4'd3, 0, 1'b0);
        check("persist_mask", 64'(trip_mask_o), 64'h20);
        check("persist_first", 64'(first_ch_o), 64'd5);
        pulse_clear();

        // alternating ch2 never reaches persist 2
        fill_mem('0);
        for (int f = 0; f < 6; f++) begin
            mem[2] = (f % 2 == 0) ? 32'hFECE_D2FF : 32'h0;
            do_scan(32'h0131_2D00, 4'd2, 0, 1'b0);
        end
        check("alt_notrip", 64'(trip_o), 64'd0);

        // exact boundaries are in-limit
        fill_mem('0);
        mem[0] = 32'h0131_2D00;
        mem[1] = 32'hFECE_D300;
        do_scan(32'h0131_2D00, 4'd1, 0, 1'b0);
        check("edge_notrip", 64'(trip_o), 64'd0);

        // most-negative limit: everything out
        do_scan(32'h8000_0000, 4'd1, 0, 1'b0);
        check("minlim_mask", 64'(trip_mask_o), 64'hFF);
        check("minlim_first", 64'(first_ch_o), 64'd0);

        // reset in the middle of a scan
        frame_start_i = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            frame_start_i = 1'b0;
            if (c >= 5) check_zero("midreset");
            if (c == 4) reset_n = 1'b0;
        end
        reset_n = 1'b1;
        model_clear();
        @(negedge clk);
        check_zero("after_midreset");

        // limit -1 with persist 0: all trip on the first frame
        do_scan(32'hFFFF_FFFF, 4'd0, 0, 1'b0);
        check("neg1_mask", 64'(trip_mask_o), 64'hFF);
        check("neg1_first", 64'(first_ch_o), 64'd0);
        pulse_clear();

        // frame strobe during a scan
        fill_mem(32'h0000_0100);
        do_scan(32'h0000_1000, 4'd1, 5, 1'b0);
`ifdef AIE_OVERRUN_EN
        check("overrun_set", 64'(overrun_o), 64'd1);
`else
        check("overrun_tied", 64'(overrun_o), 64'd0);
`endif
        pulse_clear();

        // disabled: strobes do not start a scan
        enable_i = 1'b0;
        frame_start_i = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            frame_start_i = 1'b0;
            check("dis_busy", 64'(busy_o), 64'd0);
            check("dis_rd", 64'(pos_rd_o), 64'd0);
        end
        enable_i = 1'b1;

        // clear in the same cycle as the ch4 trip
        fill_mem('0);
        mem[1] = 32'd1000;
        do_scan(32'd100, 4'd1, 0, 1'b0);
        check("pre_clr_mask", 64'(trip_mask_o), 64'h02);
        mem[1] = 32'd0;
        mem[4] = 32'd1000;
        limit_i = 32'd100;
        persist_i = 4'd1;
        frame_start_i = 1'b1;
        for (int c = 1; c <= N + 3; c++) begin
            @(negedge clk);
            frame_start_i = 1'b0;
            trip_clr_i = (c == 6);
            if (c == 7 || c == N + 3) begin
                check("cvt_trip", 64'(trip_o), 64'd1);
                check("cvt_mask", 64'(trip_mask_o), 64'h10);
                check("cvt_first", 64'(first_ch_o), 64'd4);
            end
        end
        model_clear();
        mask_m = 8'h10;
        trip_m = 1'b1;
        first_m = 4;
        cnt_m[4] = 1;
        pulse_clear();

        // randomized frames
        for (int f = 0; f < 40; f++) begin
            for (int i = 0; i < N; i++) begin
                v = int'($urandom_range(0, 8000)) - 4000;
                mem[i] = v;
            end
            oc = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, N + 2)) : 0;
            do_scan(32'($urandom_range(1000, 3500)), 4'($urandom_range(0, 4)),
                    oc, $urandom_range(0, 3) == 0);
            if ($urandom_range(0, 4) == 0) pulse_clear();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/aie_trip_ctrl.md
# aie_trip_ctrl

Active-interlock trip controller that time-shares a single envelope-limit comparator across all BPM channels of a frame. On each frame strobe it reads every channel's position from the position RAM, checks it against a symmetric ±limit window, and keeps a per-channel persistence count. A latched trip is raised once a channel stays out of limit for a programmed number of consecutive frames. It sits between the FOFB position buffer and the machine-protection output.

## Interface
- `N_CH`, default 8: number of BPM channels scanned per frame; must be 2..256.
- `CNT_W`, default 4: width of the per-channel persistence counters and of `persist_i`.
- `clk` in 1: system clock.
- `reset_n` in 1: synchronous, active-low reset.
- `enable_i` in 1: allows new scans to start.
- `frame_start_i` in 1: one-cycle pulse, new frame of positions is ready.
- `limit_i` in 32: signed int32 limit in nm; the window is [-limit, +limit].
- `persist_i` in CNT_W: number of consecutive out-of-limit frames needed to trip; 0 is treated as 1.
- `trip_clr_i` in 1: one-cycle pulse that clears all trip state.
- `pos_rd_o` out 1: read strobe to the position RAM.
- `pos_addr_o` out clog2(N_CH): channel address to read.
- `pos_data_i` in 32: signed int32 position, valid exactly 1 cycle after `pos_rd_o`.
- `busy_o` out 1: a scan is in progress.
- `scan_done_o` out 1: one-cycle pulse when a scan ends.
- `trip_o` out 1: sticky interlock trip.
- `trip_mask_o` out N_CH: sticky per-channel trip flags.
- `first_ch_o` out clog2(N_CH): channel that caused the first trip since the last clear.
- `overrun_o` out 1: sticky flag, a frame strobe arrived while busy.

## Operation
- The FSM has four states: IDLE, READ, DRAIN, DONE.
  - IDLE goes to READ on `frame_start_i && enable_i`.
  - READ issues one read per cycle for addresses 0..N_CH-1, then goes to DRAIN.
  - DRAIN checks the last returned sample, then goes to DONE.
  - DONE pulses `scan_done_o` and returns to IDLE.
- Sample `limit_i` and `persist_i` into registers on scan start. They are constant for the whole scan.
- Limit check on a sample `p`, with `L` the sampled limit:
  - in-limit = (p <= L) && (p >= -L).
  - Compute -L in 33-bit signed so that L = 0x80000000 does not overflow.
  - Negative L marks every channel out of limit.
- Per-channel counter update:
  - In-limit sample: counter goes to 0.
  - Out-of-limit sample: counter increments, saturating at 2^CNT_W-1.
- Trip condition: updated count >= max(persist_i, 1).
  - Set `trip_mask_o[ch]` and `trip_o`.
  - If `trip_o` was 0, capture `ch` into `first_ch_o`.
  - If several channels trip in one scan, the lowest address is captured, because channels are checked in address order.
- `trip_clr_i` clears `trip_o`, `trip_mask_o`, `first_ch_o`, `overrun_o` and all counters.
  - A trip detected in the same cycle as the clear wins: its bit is set and its count stays.
- `enable_i` deasserted mid-scan: the current scan completes; no new scan starts.
- `frame_start_i` while `busy_o`=1 is ignored (no restart) and sets `overrun_o`.
- Reset:
  - All outputs, counters and the FSM go to 0 / IDLE.
  - Reset mid-scan abandons the scan with no `scan_done_o`.

## Timing
- Cycle 0: `frame_start_i` is sampled high in IDLE.
- Cycles 1..N_CH: `pos_rd_o`=1, with `pos_addr_o` = cycle-1.
- Cycle k+2: `pos_data_i` holds channel k.
- A trip caused by channel k is visible on `trip_o` / `trip_mask_o` / `first_ch_o` in cycle k+3.
- `scan_done_o` is high in cycle N_CH+2.
- `busy_o` is high for cycles 1..N_CH+2.
- The next `frame_start_i` is accepted from cycle N_CH+3. A strobe in cycles 1..N_CH+2 is an overrun.
- Reset values: every output is 0.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `AIE_OVERRUN_EN` defined: overrun detection is built as described, and `overrun_o` is sticky until `trip_clr_i` or reset.
- `AIE_OVERRUN_EN` undefined: no overrun logic is built, and `overrun_o` is tied to 0. Strobes during a scan are still ignored.

## Test plan
All scenarios use N_CH=8, CNT_W=4.

- **In-limit scan:** limit 0x01312D00, all positions 0x00100000, persist 3, 4 frames -> `trip_o`=0, `trip_mask_o`=0x00, `scan_done_o` in cycle 10 of each scan.
- **Persistence trip:** ch5 = 0x01312D01, others 0.
  - Frames 1-2 -> no trip.
  - Frame 3 -> `trip_o`=1 in cycle 8, `trip_mask_o`=0x20, `first_ch_o`=5.
- **Counter reset:** ch2 alternates 0xFECED2FF / 0 over 6 frames with persist 2 -> never trips.
- **Boundary values:**
  - ch0=0x01312D00 and ch1=0xFECED300 -> in-limit, no trip.
  - limit 0x80000000 -> no overflow, every channel out of limit.
  - limit 0xFFFFFFFF with persist 0 -> all channels trip on frame 1, `trip_mask_o`=0xFF, `first_ch_o`=0.
- **Clear vs trip:** `trip_clr_i` pulsed in the same cycle as a ch4 trip -> `trip_mask_o`=0x10, `trip_o`=1 afterwards.
- **Overrun and reset:**
  - `frame_start_i` at cycle 5 of a scan -> ignored, `overrun_o`=1 with `AIE_OVERRUN_EN`, 0 without.
  - `reset_n`=0 at cycle 4 -> all outputs 0 next cycle, no `scan_done_o`.
